// File: rtl/data_mem_ctrl.sv
// Data-memory controller: valid/ready load/store front end over a word-wide RAM with a
// registered read port, byte-lane writes and a two-beat sequence for word-crossing accesses.
module data_mem_ctrl #(
    parameter int XLEN             = 32,
    parameter int DEPTH            = 64,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [AW+1:0]     addr_reg;
    logic [XLEN-1:0]   wdata_reg;

    logic [XLEN-1:0]   ram [DEPTH];
    logic [XLEN-1:0]   rd_data_reg;
    logic [XLEN-1:0]   beat0_hold_reg;

    logic [1:0]        offset;
    logic [2:0]        size;
    logic [3:0]        end_pos;
    logic              illegal;
    logic              misaligned;
    logic              crossing;
    logic              err;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     ram_idx;
    logic              ram_en;
    logic [3:0]        byte_we;
    logic [XLEN-1:0]   ram_wdata;
    logic [7:0]        lane_mask;
    logic [2*XLEN-1:0] wdata_shift;
    logic [2*XLEN-1:0] rd_pair;
    logic [XLEN-1:0]   load_src;
    logic [XLEN-1:0]   load_word;
    logic              unused_addr_bits;

    // Address bits above the word index are ignored, so indexing wraps modulo DEPTH.
    assign unused_addr_bits = ^req_addr[XLEN-1:AW+2];

    always_comb begin
        offset = addr_reg[1:0];
        idx    = addr_reg[AW+1:2];
        case (funct3_reg[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        end_pos    = {2'b00, offset} + {1'b0, size};
        illegal    = (funct3_reg == 3'b011) || (funct3_reg[2] && funct3_reg[1])
                     || (we_reg && funct3_reg[2]);
        misaligned = ((size == 3'd2) && offset[0]) || ((size == 3'd4) && (offset != 2'd0));
        crossing   = end_pos > 4'd4;
        err        = illegal || (misaligned && !ALLOW_MISALIGNED);
    end

    // Store bytes and their lane enables, laid out across two consecutive words:
    // the low half belongs to beat 0, the high half to beat 1.
    always_comb begin
        lane_mask   = 8'(((8'd1 << size) - 8'd1) << offset);
        wdata_shift = {{XLEN{1'b0}}, wdata_reg} << {offset, 3'b000};
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_idx   = idx;
        byte_we   = 4'b0000;
        ram_wdata = wdata_shift[XLEN-1:0];
        case (state_reg)
            BEAT0: begin
                if (!err) begin
                    ram_en  = 1'b1;
                    byte_we = we_reg ? lane_mask[3:0] : 4'b0000;
                end
            end
            BEAT1: begin
                ram_en    = 1'b1;
                ram_idx   = idx + AW'(1);
                byte_we   = we_reg ? lane_mask[7:4] : 4'b0000;
                ram_wdata = wdata_shift[2*XLEN-1:XLEN];
            end
            default: ;
        endcase
    end

    // Single RAM port, read-before-write; the read register only moves during a beat,
    // which keeps the response data stable while RESP is stalled.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            rd_data_reg <= ram[ram_idx];
            for (int i = 0; i < 4; i++) begin
                if (byte_we[i]) begin
                    ram[ram_idx][i*8 +: 8] <= ram_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == BEAT1) begin
            beat0_hold_reg <= rd_data_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr[AW+1:0];
                wdata_reg  <= req_wdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = BEAT0;
            BEAT0:   state_next = (!err && crossing) ? BEAT1 : RESP;
            BEAT1:   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load bytes start at the offset in the beat-0 word and spill into the beat-1 word.
    always_comb begin
        rd_pair  = {rd_data_reg, (crossing ? beat0_hold_reg : rd_data_reg)};
        load_src = rd_pair[{offset, 3'b000} +: XLEN];
        case (funct3_reg)
            3'b000:  load_word = {{(XLEN-8){load_src[7]}}, load_src[7:0]};
            3'b001:  load_word = {{(XLEN-16){load_src[15]}}, load_src[15:0]};
            3'b010:  load_word = load_src;
            3'b100:  load_word = {{(XLEN-8){1'b0}}, load_src[7:0]};
            3'b101:  load_word = {{(XLEN-16){1'b0}}, load_src[15:0]};
            default: load_word = '0;
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = (state_reg == RESP) && err;
    assign rsp_rdata = ((state_reg == RESP) && !err && !we_reg) ? load_word : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one misalignment-tolerant and one strict instance, directed
// steps followed by random traffic checked against a byte-array memory model.
module tb_data_mem_ctrl;

    localparam int DEPTH = 64;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_ready;
    logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;

    logic        sel;
    logic        s_req_ready, s_rsp_valid, s_rsp_err;
    logic [31:0] s_rsp_rdata;

    int total = 0;
    int bad = 0;

    // Reference memory per instance: index 0 = misaligned allowed, 1 = strict.
    logic [7:0] mem_m [2][NBYTES];

    always #5 clk = ~clk;

    data_mem_ctrl #(.XLEN(32), .DEPTH(DEPTH), .ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    data_mem_ctrl #(.XLEN(32), .DEPTH(DEPTH), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    assign s_req_ready = sel ? req_ready_b : req_ready_a;
    assign s_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign s_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
    assign s_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model(input logic inst, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_err, output int exp_lat);
        int size;
        int off;
        logic illegal;
        logic mis;
        logic [7:0] bi;
        logic [31:0] v;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off     = int'(addr % 4);
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
        mis     = (addr % size) != 0;
        exp_err = illegal || (mis && inst);
        exp_lat = (!exp_err && (off + size > 4)) ? 3 : 2;
        exp_rd  = 32'h0;
        v       = 32'h0;
        if (!exp_err) begin
            for (int i = 0; i < size; i++) begin
                bi = addr[7:0] + 8'(i);
                if (we) mem_m[inst][bi] = wd[8*i +: 8];
                else    v[8*i +: 8] = mem_m[inst][bi];
            end
            if (!we) begin
                if (f3 == 3'd0)      exp_rd = {{24{v[7]}}, v[7:0]};
                else if (f3 == 3'd1) exp_rd = {{16{v[15]}}, v[15:0]};
                else                 exp_rd = v;
            end
        end
    endtask

    // One full request/response exchange; hold = cycles rsp_ready is kept low.
    task automatic txn(input logic inst, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold,
                       input string tag, output logic [31:0] got_rd, output logic got_err);
        logic [31:0] er;
        logic ee;
        int el;
        int lat;
        int w;
        model(inst, we, f3, addr, wd, er, ee, el);
        sel = inst;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = (hold == 0);
        if (inst) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        w = 0;
        while (s_req_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk({tag, "_accept"}, 32'(s_req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (s_rsp_valid !== 1'b1 && lat < 20);
        chk({tag, "_lat"}, 32'(lat), 32'(el));
        chk({tag, "_rdata"}, s_rsp_rdata, er);
        chk({tag, "_err"}, 32'(s_rsp_err), 32'(ee));
        got_rd = s_rsp_rdata;
        got_err = s_rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_flags"}, {29'd0, s_rsp_valid, s_req_ready, s_rsp_err}, {29'd0, 1'b1, 1'b0, got_err});
            chk({tag, "_hold_rdata"}, s_rsp_rdata, got_rd);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, s_rsp_valid, s_req_ready}, 32'd1);
        $display("txn %s inst=%0d we=%0d f3=%0d addr=%h wd=%h rd=%h err=%0d lat=%0d",
                 tag, inst, we, f3, addr, wd, got_rd, got_err, lat);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a_flags"}, {29'd0, req_ready_a, rsp_valid_a, rsp_err_a}, 32'd4);
        chk({tag, "_a_rdata"}, rsp_rdata_a, 32'd0);
        chk({tag, "_b_flags"}, {29'd0, req_ready_b, rsp_valid_b, rsp_err_b}, 32'd4);
        chk({tag, "_b_rdata"}, rsp_rdata_b, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        logic [2:0] f3tab [10];
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        sel = 1'b0;
        rst_n = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++) begin
            txn(1'b0, 1'b1, 3'd2, 32'(w * 4), 32'd0, 0, "init_a", rd, er);
            txn(1'b1, 1'b1, 3'd2, 32'(w * 4), 32'd0, 0, "init_b", rd, er);
        end

        txn(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "sw10", rd, er);
        txn(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10", rd, er);
        chk("lw10_const", rd, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 3'd0, 32'h13, 32'h0, 0, "lb13", rd, er);
        chk("lb13_const", rd, 32'hFFFFFFDE);
        txn(1'b0, 1'b0, 3'd4, 32'h11, 32'h0, 0, "lbu11", rd, er);
        chk("lbu11_const", rd, 32'h000000BE);
        txn(1'b0, 1'b0, 3'd1, 32'h12, 32'h0, 0, "lh12", rd, er);
        chk("lh12_const", rd, 32'hFFFFDEAD);
        txn(1'b0, 1'b0, 3'd5, 32'h12, 32'h0, 0, "lhu12", rd, er);
        chk("lhu12_const", rd, 32'h0000DEAD);
        txn(1'b0, 1'b1, 3'd0, 32'h21, 32'h55, 0, "sb21", rd, er);
        txn(1'b0, 1'b0, 3'd2, 32'h20, 32'h0, 0, "lw20", rd, er);
        chk("lw20_const", rd, 32'h00005500);

        txn(1'b0, 1'b1, 3'd2, 32'hFE, 32'h11223344, 0, "sw_fe_wrap", rd, er);
        txn(1'b0, 1'b0, 3'd2, 32'hFC, 32'h0, 0, "lw_fc", rd, er);
        chk("lw_fc_const", rd, 32'h33440000);
        txn(1'b0, 1'b0, 3'd2, 32'h00, 32'h0, 0, "lw_00", rd, er);
        chk("lw_00_const", rd, 32'h00001122);
        txn(1'b0, 1'b0, 3'd2, 32'hFE, 32'h0, 0, "lw_fe_wrap", rd, er);
        chk("lw_fe_const", rd, 32'h11223344);
        txn(1'b0, 1'b1, 3'd4, 32'h40, 32'hFFFFFFFF, 0, "sbu_illegal", rd, er);
        chk("sbu_illegal_err", 32'(er), 32'd1);

        txn(1'b1, 1'b1, 3'd1, 32'h31, 32'hABCD, 0, "sh31_strict", rd, er);
        chk("sh31_err", 32'(er), 32'd1);
        chk("sh31_rdata", rd, 32'd0);
        txn(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, 0, "lw30_strict", rd, er);
        chk("lw30_unchanged", rd, 32'd0);
        txn(1'b1, 1'b0, 3'd3, 32'h30, 32'h0, 0, "f3_011_strict", rd, er);
        chk("f3_011_err", 32'(er), 32'd1);

        txn(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, 4, "lw10_hold", rd, er);
        chk("lw10_hold_const", rd, 32'hDEADBEEF);

        // Reset while the second beat of a split store is pending.
        sel = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h7E; req_wdata = 32'hA1B2C3D4;
        rsp_ready = 1'b1; req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        @(posedge clk);
        #2;
        chk("split_pending_valid", 32'(rsp_valid_a), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset("reset_mid_split");
        mem_m[0][8'h7E] = 8'hD4;
        mem_m[0][8'h7F] = 8'hC3;
        $display("txn reset_mid_split inst=0 we=1 f3=2 addr=0000007e wd=a1b2c3d4");
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 1'b0, 3'd2, 32'h7C, 32'h0, 0, "lw7c_after_rst", rd, er);
        chk("lw7c_beat0_kept", rd, 32'hC3D40000);
        txn(1'b0, 1'b0, 3'd2, 32'h80, 32'h0, 0, "lw80_after_rst", rd, er);
        chk("lw80_beat1_lost", rd, 32'h00000000);

        for (int n = 0; n < 120; n++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3tab[$urandom_range(0, 9)],
                $urandom, $urandom, int'($urandom_range(0, 2)), "rand", rd, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory controller for the RISC-V core, replacing the combinational-read data memory. Loads and stores use a valid/ready request channel and a valid/ready response channel. The read path is registered, all byte/halfword offsets are handled correctly for both sign- and zero-extended loads, and an optional two-beat sequencer services word-boundary-crossing accesses. It sits between the load/store unit and the word-organised data RAM.

## Interface
- XLEN, 32, data and address width (32 only is supported)
- DEPTH, 64, number of XLEN-bit words; must be a power of two
- ALLOW_MISALIGNED, 1, 1 = misaligned accesses are split/serviced; 0 = they fault
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  XLEN  load result, extended per funct3; 0 for stores and errors
- rsp_err  out  1  illegal funct3 or disallowed misalignment

## Operation
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so indexing wraps modulo DEPTH. Byte offset = addr[1:0]. Little-endian.
- Size: 1 byte (000/100), 2 bytes (001/101), 4 bytes (010).
- Illegal requests set err and perform no RAM write:
  - funct3 011/110/111;
  - store with funct3 100/101.
- Misaligned: half at an odd offset, or word at a nonzero offset.
- Crossing: offset + size > 4. This covers half at offset 3 and word at offsets 1–3.
- With ALLOW_MISALIGNED=0, any misaligned request sets err with no write.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and go to BEAT0.
  - BEAT0: if err, write nothing and go to RESP. Otherwise access word idx: write the enabled lanes (offset .. min(offset+size,4)-1) from the low bytes of wdata, and register the read word. If crossing, go to BEAT1; else go to RESP.
  - BEAT1: access word (idx+1) mod DEPTH. Write lanes 0 .. (offset+size-5) from the remaining wdata bytes, and register the read word. Go to RESP.
  - RESP: rsp_valid=1. Stay until rsp_ready=1, then go to IDLE.
- Load assembly:
  - Take bytes from beat0 starting at offset, continuing into beat1 low bytes.
  - Sign-extend for 000/001; zero-extend for 100/101; no extension for 010.
- Read data is the RAM content before the same-beat write (loads never write, so this matters only for stores, whose rdata is 0).
- RAM is not reset; its contents are undefined until written.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE;
  - req_ready=1;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Accept on edge N. BEAT0 is performed at edge N+1. rsp_valid goes high after edge N+1 (non-crossing or error), or after edge N+2 (crossing).
- rsp_rdata and rsp_err are stable while rsp_valid is high. With rsp_ready held at 1, the response lasts exactly one cycle. req_ready returns 1 the cycle after the rsp handshake.
- Back-to-back throughput: one non-crossing access per 3 cycles with rsp_ready=1.
- No request is accepted while busy; req_valid held during busy has no effect until IDLE.
- A store in flight is complete in RAM before its rsp_valid. A load issued after that response observes the store.
- Reset mid-split (between BEAT0 and BEAT1): the beat0 write persists, the beat1 write is lost, and no response is issued.
- Index wrap: a crossing access at word DEPTH-1 uses word 0 for beat1.

## Test plan
- After reset, sw addr 0x10 data 0xDEADBEEF, then lw 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
- Then lb 0x13 → 0xFFFFFFDE; lbu 0x11 → 0x000000BE; lh 0x12 → 0xFFFFDEAD; lhu 0x12 → 0x0000DEAD.
- sb 0x21 data 0x55 into a word holding 0x00000000, then lw 0x20 → 0x00005500.
- ALLOW_MISALIGNED=1, DEPTH=64: sw 0xFE data 0x11223344 splits across word 63 and word 0 (wrap). Required: 3-cycle latency; lw 0xFC → 0x3344xxxx (upper half); lw 0x00 → 0xxxxx1122 (lower half); lw 0xFE → 0x11223344.
- ALLOW_MISALIGNED=0: sh 0x31 → rsp_err=1, rsp_rdata=0, and word 0x30 unchanged. funct3=011 load → rsp_err=1.
- Hold rsp_ready=0 for 4 cycles: rsp_valid and data stay stable and req_ready=0. Assert rst_n low during BEAT1 of a split store: all outputs go to reset values immediately and the beat0 bytes are present in RAM.
